dsp38_mac_sequencer: RTL and testbench
======================================

# dsp38_mac_sequencer

Operand-side controller for a DSP38 in MULTIPLY_ACCUMULATE mode with input and output registers enabled. It accepts (A, B) operand pairs over a valid/ready stream and drives the DSP38 A/B/LOAD_ACC/FEEDBACK/control pins for an NUM_TAPS-term dot product. It tracks the DSP pipeline latency and captures the final Z into a held result with its own valid/ready handshake. It sits between operand-fetch logic and the DSP38 instance, in place of direct buffered pin drive.

## Interface
Parameters:
- NUM_TAPS, 8: products per dot product; legal range 1..64.
- DSP_LATENCY, 2: cycles from operand drive to Z reflecting that operand; legal range 1..4.
- SHIFT_RIGHT_VAL, 6'd0: constant driven on DSP_SHIFT_RIGHT.
- ROUND_EN, 1'b0: constant driven on DSP_ROUND.
- SATURATE_EN, 1'b0: constant driven on DSP_SATURATE.
- UNSIGNED_A_EN, 1'b0: constant driven on DSP_UNSIGNED_A.
- UNSIGNED_B_EN, 1'b0: constant driven on DSP_UNSIGNED_B.

Ports:
- CLK  in  1  single clock.
- RESET  in  1  synchronous, active-low reset.
- CLEAR  in  1  synchronous abort of the current dot product.
- S_VALID  in  1  operand pair valid.
- S_READY  out  1  operand pair accepted when S_VALID&S_READY.
- S_A  in  20  multiplicand.
- S_B  in  18  multiplier.
- S_SUB  in  1  subtract this product instead of adding it.
- DSP_A  out  20  to DSP38 A.
- DSP_B  out  18  to DSP38 B.
- DSP_LOAD_ACC  out  1  to DSP38 LOAD_ACC.
- DSP_FEEDBACK  out  3  to DSP38 FEEDBACK.
- DSP_SUBTRACT  out  1  to DSP38 SUBTRACT.
- DSP_SHIFT_RIGHT, DSP_ROUND, DSP_SATURATE, DSP_UNSIGNED_A, DSP_UNSIGNED_B  out  6/1/1/1/1  parameter constants.
- DSP_RESET  out  1  to DSP38 RESET; equals RESET (active-low).
- DSP_Z  in  38  from DSP38 Z.
- M_VALID  out  1  result valid.
- M_READY  in  1  result accepted when M_VALID&M_READY.
- M_Z  out  38  dot-product result.
- TAP_CNT  out  6  taps accepted in the current dot product.

## Operation
- Accept = S_VALID & S_READY.
- S_READY = (state==ACCUM) & RESET & ~CLEAR. This is combinational.
- DSP_A/DSP_B/DSP_SUBTRACT are combinational pass-through of S_A/S_B/S_SUB.
- DSP_LOAD_ACC = accept.
- DSP_FEEDBACK = 3'd1 (load product, discard old accumulator) when TAP_CNT==0; otherwise 3'd0 (accumulate).
- The DSP accumulator holds while DSP_LOAD_ACC=0. Idle cycles between taps are legal and do not disturb the sum.
- FSM states are ACCUM, DRAIN and HOLD. Reset state is ACCUM.
  - ACCUM: on accept, TAP_CNT increments. On the accept where TAP_CNT==NUM_TAPS-1, TAP_CNT returns to 0, drain_cnt loads DSP_LATENCY and the FSM goes to DRAIN.
  - DRAIN: S_READY=0. drain_cnt decrements each cycle. In the cycle with drain_cnt==1, DSP_Z is registered into M_Z and the FSM goes to HOLD.
  - HOLD: M_VALID=1 and M_Z is stable. On M_READY the FSM goes to ACCUM and M_VALID falls on the next edge.
- No operand/result overlap: S_READY=0 throughout DRAIN and HOLD.
- NUM_TAPS=1: every accept uses FEEDBACK=1 and goes straight to DRAIN.
- Arithmetic is performed entirely in the DSP38. The block never modifies Z and M_Z is a bit-exact copy of DSP_Z.
- CLEAR=1 (any state):
  - Next state is ACCUM, TAP_CNT=0, M_VALID=0 and any pending result is dropped.
  - CLEAR has priority over accept and over result handshake.
  - A concurrent S_VALID is not accepted and LOAD_ACC=0.
- RESET=0 (sampled at edge):
  - State ACCUM, TAP_CNT=0, drain_cnt=0, M_VALID=0, M_Z=38'd0.
  - During reset cycles: S_READY=0, DSP_LOAD_ACC=0, DSP_RESET=0.

## Timing
- Last tap accepted in cycle t: DRAIN occupies t+1..t+DSP_LATENCY, M_Z captured at the end of cycle t+DSP_LATENCY, M_VALID=1 from cycle t+DSP_LATENCY+1.
- Default latency is 3 cycles from last accept to M_VALID.
- Minimum dot-product period is NUM_TAPS + DSP_LATENCY + 1 cycles, plus M_READY wait.
- M_READY held high in HOLD: S_READY is 1 in the following cycle.
- Reset mid-DRAIN or mid-HOLD: the result is lost and M_VALID is 0 the cycle after reset deasserts.

## Test plan
- NUM_TAPS=4: stream A=1,2,3,4 with B=10 back-to-back from cycle 0 -> LOAD_ACC high on cycles 0..3, FEEDBACK=1 only on cycle 0, M_VALID first high at cycle 6, M_Z=100.
- Same stream with S_VALID gaps (pattern 1,0,0,1,1,0,1) -> M_Z=100, M_VALID 3 cycles after the 4th accept, LOAD_ACC=0 on gap cycles.
- S_SUB=1 on the 2nd tap, A=5,7,-3,2 and B=-4 (signed) -> M_Z = -4·(5-7-3+2) = 12 sign-extended to 38 bits.
- M_READY held low 10 cycles in HOLD -> M_Z stable, S_READY=0 throughout, S_READY=1 the cycle after M_READY handshake; next dot product is unaffected by the prior sum.
- CLEAR pulsed after 2 of 4 taps, then 4 taps of A=1, B=1 -> M_Z=4, TAP_CNT=0 the cycle after CLEAR; CLEAR coincident with S_VALID -> no accept.
- RESET low during DRAIN -> M_VALID=0, M_Z=0, DSP_RESET=0; a fresh dot product after release gives the correct sum.

Source files
------------

// File: rtl/dsp38_mac_sequencer.sv
// Operand-side sequencer for a DSP38 running multiply-accumulate: streams NUM_TAPS
// operand pairs into the DSP, waits out its pipeline and holds the final Z for a consumer.
module dsp38_mac_sequencer #(
   parameter int          NUM_TAPS        = 8,
   parameter int          DSP_LATENCY     = 2,
   parameter logic [5:0]  SHIFT_RIGHT_VAL = 6'd0,
   parameter logic        ROUND_EN        = 1'b0,
   parameter logic        SATURATE_EN     = 1'b0,
   parameter logic        UNSIGNED_A_EN   = 1'b0,
   parameter logic        UNSIGNED_B_EN   = 1'b0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CLEAR,
   input  logic        S_VALID,
   output logic        S_READY,
   input  logic [19:0] S_A,
   input  logic [17:0] S_B,
   input  logic        S_SUB,
   output logic [19:0] DSP_A,
   output logic [17:0] DSP_B,
   output logic        DSP_LOAD_ACC,
   output logic [2:0]  DSP_FEEDBACK,
   output logic        DSP_SUBTRACT,
   output logic [5:0]  DSP_SHIFT_RIGHT,
   output logic        DSP_ROUND,
   output logic        DSP_SATURATE,
   output logic        DSP_UNSIGNED_A,
   output logic        DSP_UNSIGNED_B,
   output logic        DSP_RESET,
   input  logic [37:0] DSP_Z,
   output logic        M_VALID,
   input  logic        M_READY,
   output logic [37:0] M_Z,
   output logic [5:0]  TAP_CNT
);

   typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

   localparam logic [5:0] LAST_TAP  = 6'(NUM_TAPS - 1);
   localparam logic [2:0] DRAIN_LEN = 3'(DSP_LATENCY);

   state_t      state_q, state_d;
   logic [5:0]  tap_q, tap_d;
   logic [2:0]  drain_q, drain_d;
   logic [37:0] mz_q, mz_d;
   logic        accept;

   assign S_READY = (state_q == ACCUM) & RESET & ~CLEAR;
   assign accept  = S_VALID & S_READY;

   assign DSP_A           = S_A;
   assign DSP_B           = S_B;
   assign DSP_SUBTRACT    = S_SUB;
   assign DSP_LOAD_ACC    = accept;
   // The first tap overwrites the accumulator, so no explicit DSP clear is needed.
   assign DSP_FEEDBACK    = (tap_q == 6'd0) ? 3'd1 : 3'd0;
   assign DSP_SHIFT_RIGHT = SHIFT_RIGHT_VAL;
   assign DSP_ROUND       = ROUND_EN;
   assign DSP_SATURATE    = SATURATE_EN;
   assign DSP_UNSIGNED_A  = UNSIGNED_A_EN;
   assign DSP_UNSIGNED_B  = UNSIGNED_B_EN;
   assign DSP_RESET       = RESET;

   assign M_VALID = (state_q == HOLD);
   assign M_Z     = mz_q;
   assign TAP_CNT = tap_q;

   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      drain_d = drain_q;
      mz_d    = mz_q;
      if (CLEAR) begin
         state_d = ACCUM;
         tap_d   = 6'd0;
         drain_d = 3'd0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept) begin
                  if (tap_q == LAST_TAP) begin
                     tap_d   = 6'd0;
                     drain_d = DRAIN_LEN;
                     state_d = DRAIN;
                  end else begin
                     tap_d = tap_q + 6'd1;
                  end
               end
            end
            DRAIN: begin
               drain_d = drain_q - 3'd1;
               if (drain_q <= 3'd1) begin
                  drain_d = 3'd0;
                  mz_d    = DSP_Z;
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (M_READY) state_d = ACCUM;
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= ACCUM;
         tap_q   <= 6'd0;
         drain_q <= 3'd0;
         mz_q    <= 38'd0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         drain_q <= drain_d;
         mz_q    <= mz_d;
      end
   end

endmodule

// File: tb/tb_dsp38_mac_sequencer.sv
// Directed bench for dsp38_mac_sequencer with a small two-stage DSP38 MAC model on the Z side.
module tb_dsp38_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, clear, s_valid, s_sub, m_ready;
   logic [19:0] s_a;
   logic [17:0] s_b;
   logic        s_ready, dsp_load_acc, dsp_subtract, dsp_round, dsp_saturate;
   logic        dsp_unsigned_a, dsp_unsigned_b, dsp_reset, m_valid;
   logic [19:0] dsp_a;
   logic [17:0] dsp_b;
   logic [2:0]  dsp_feedback;
   logic [5:0]  dsp_shift_right, tap_cnt;
   logic [37:0] dsp_z, m_z;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_tap = 0;

   always #5 clk = ~clk;

   dsp38_mac_sequencer #(.NUM_TAPS(4), .DSP_LATENCY(2)) dut (
      .CLK(clk), .RESET(rst_n), .CLEAR(clear),
      .S_VALID(s_valid), .S_READY(s_ready), .S_A(s_a), .S_B(s_b), .S_SUB(s_sub),
      .DSP_A(dsp_a), .DSP_B(dsp_b), .DSP_LOAD_ACC(dsp_load_acc), .DSP_FEEDBACK(dsp_feedback),
      .DSP_SUBTRACT(dsp_subtract), .DSP_SHIFT_RIGHT(dsp_shift_right), .DSP_ROUND(dsp_round),
      .DSP_SATURATE(dsp_saturate), .DSP_UNSIGNED_A(dsp_unsigned_a), .DSP_UNSIGNED_B(dsp_unsigned_b),
      .DSP_RESET(dsp_reset), .DSP_Z(dsp_z),
      .M_VALID(m_valid), .M_READY(m_ready), .M_Z(m_z), .TAP_CNT(tap_cnt)
   );

   // DSP38 model: input register stage, then accumulator/output register.
   logic [19:0]        a_r;
   logic [17:0]        b_r;
   logic               sub_r, load_r;
   logic [2:0]         fb_r;
   logic signed [37:0] prod, acc;

   always_comb prod = $signed({{18{a_r[19]}}, a_r}) * $signed({{20{b_r[17]}}, b_r});

   always @(posedge clk) begin
      if (!dsp_reset) begin
         a_r <= '0; b_r <= '0; sub_r <= 1'b0; load_r <= 1'b0; fb_r <= '0; acc <= '0;
      end else begin
         a_r <= dsp_a; b_r <= dsp_b; sub_r <= dsp_subtract; load_r <= dsp_load_acc; fb_r <= dsp_feedback;
         if (load_r)
            acc <= ((fb_r == 3'd1) ? 38'sd0 : acc) + (sub_r ? -prod : prod);
      end
   end
   assign dsp_z = acc;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [19:0] a, input logic [17:0] b, input logic sub,
                        input logic mr, input logic clr, input logic rn);
      @(negedge clk);
      s_valid = v; s_a = a; s_b = b; s_sub = sub; m_ready = mr; clear = clr; rst_n = rn;
      #1;
   endtask

   task automatic feed(input logic [19:0] a, input logic [17:0] b, input logic sub);
      drive(1'b1, a, b, sub, 1'b0, 1'b0, 1'b1);
      check_eq("feed_s_ready", s_ready, 1);
      check_eq("feed_load_acc", dsp_load_acc, 1);
      check_eq("feed_tap_cnt", tap_cnt, exp_tap);
      check_eq("feed_feedback", dsp_feedback, (exp_tap == 0) ? 1 : 0);
      check_eq("feed_dsp_a", dsp_a, a);
      $display("tap %0d: A=%0h B=%0h sub=%0b fb=%0d", exp_tap, a, b, sub, dsp_feedback);
      exp_tap = (exp_tap + 1) % 4;
   endtask

   task automatic gap();
      drive(1'b0, 20'hABCDE, 18'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("gap_load_acc", dsp_load_acc, 0);
      check_eq("gap_tap_cnt", tap_cnt, exp_tap);
   endtask

   task automatic wait_result(input logic [37:0] exp_z, input int hold_cycles);
      int n = 0;
      do begin
         drive(1'b0, 20'd0, 18'd0, 1'b0, 1'b0, 1'b0, 1'b1);
         n++;
         if (!m_valid) check_eq("drain_s_ready", s_ready, 0);
      end while (!m_valid && n < 20);
      check_eq("result_latency", n, 3);
      check_eq("result_m_z", m_z, exp_z);
      $display("result: M_Z=%0h after %0d cycles", m_z, n);
      for (int i = 0; i < hold_cycles; i++) begin
         drive(1'b1, 20'd1, 18'd1, 1'b0, 1'b0, 1'b0, 1'b1);
         check_eq("hold_m_valid", m_valid, 1);
         check_eq("hold_s_ready", s_ready, 0);
         check_eq("hold_m_z", m_z, exp_z);
      end
      drive(1'b0, 20'd0, 18'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("hs_m_valid", m_valid, 1);
      check_eq("hs_s_ready", s_ready, 0);
      drive(1'b0, 20'd0, 18'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("post_hs_m_valid", m_valid, 0);
      check_eq("post_hs_s_ready", s_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      s_valid = 0; s_a = 0; s_b = 0; s_sub = 0; m_ready = 0; clear = 0; rst_n = 0;
      repeat (3) drive(1'b1, 20'd1, 18'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("rst_s_ready", s_ready, 0);
      check_eq("rst_load_acc", dsp_load_acc, 0);
      check_eq("rst_dsp_reset", dsp_reset, 0);
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_m_z", m_z, 0);
      check_eq("rst_tap_cnt", tap_cnt, 0);

      // Back-to-back 1..4 x 10, then a long M_READY stall.
      for (int i = 1; i <= 4; i++) feed(20'(i), 18'd10, 1'b0);
      wait_result(38'd100, 10);

      // Gapped stream: valid pattern 1,0,0,1,1,0,1.
      feed(20'd1, 18'd10, 1'b0); gap(); gap();
      feed(20'd2, 18'd10, 1'b0); feed(20'd3, 18'd10, 1'b0); gap();
      feed(20'd4, 18'd10, 1'b0);
      wait_result(38'd100, 0);

      // Signed with subtract on tap 2: -4*(5-7-3+2) = 12.
      feed(20'd5, -18'sd4, 1'b0);
      feed(20'd7, -18'sd4, 1'b1);
      feed(-20'sd3, -18'sd4, 1'b0);
      feed(20'd2, -18'sd4, 1'b0);
      wait_result(38'd12, 0);

      // CLEAR after two taps, coincident with S_VALID.
      feed(20'd9, 18'd9, 1'b0);
      feed(20'd9, 18'd9, 1'b0);
      drive(1'b1, 20'd9, 18'd9, 1'b0, 1'b0, 1'b1, 1'b1);
      check_eq("clr_s_ready", s_ready, 0);
      check_eq("clr_load_acc", dsp_load_acc, 0);
      exp_tap = 0;
      gap();
      for (int i = 0; i < 4; i++) feed(20'd1, 18'd1, 1'b0);
      wait_result(38'd4, 0);

      // Reset during DRAIN drops the result.
      for (int i = 1; i <= 4; i++) feed(20'(i), 18'd10, 1'b0);
      drive(1'b0, 20'd0, 18'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("drain_m_valid", m_valid, 0);
      repeat (2) begin
         drive(1'b1, 20'd1, 18'd1, 1'b0, 1'b1, 1'b0, 1'b0);
         check_eq("rst2_dsp_reset", dsp_reset, 0);
         check_eq("rst2_s_ready", s_ready, 0);
      end
      drive(1'b0, 20'd0, 18'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("rst2_m_valid", m_valid, 0);
      check_eq("rst2_m_z", m_z, 0);
      exp_tap = 0;
      for (int i = 0; i < 4; i++) feed(20'd2, 18'd3, 1'b0);
      wait_result(38'd24, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
